// File: rtl/button_press_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : button_press_counter_pkg
//  Brief    : Shared constants, leader encoding and display helper functions
//  Revision : 1.0 - initial release
// ============================================================================
package button_press_counter_pkg;

    localparam int          NUM_BUTTONS = 3;
    localparam int          c_IND_WIDTH = 10;

    localparam logic [7:0]  SEG_DIGIT0  = 8'hC0;
    localparam logic [7:0]  SEG_DIGIT1  = 8'hF9;
    localparam logic [7:0]  SEG_DIGIT2  = 8'hA4;
    localparam logic [7:0]  SEG_TIE     = 8'h7F;

    typedef enum logic [1:0] {
        LEAD_0   = 2'd0,
        LEAD_1   = 2'd1,
        LEAD_2   = 2'd2,
        LEAD_TIE = 2'd3
    } leader_e;

    function automatic logic [7:0] seg_encode(input leader_e lead);
        logic [7:0] seg;
        case (lead)
            LEAD_0:  seg = SEG_DIGIT0;
            LEAD_1:  seg = SEG_DIGIT1;
            LEAD_2:  seg = SEG_DIGIT2;
            default: seg = SEG_TIE;
        endcase
        return seg;
    endfunction

    // Lowest min(n, c_IND_WIDTH) bits set.
    function automatic logic [c_IND_WIDTH-1:0] thermometer(input int unsigned n);
        logic [c_IND_WIDTH-1:0] t;
        if (n >= c_IND_WIDTH)
            t = '1;
        else
            t = (c_IND_WIDTH'(1) << n) - c_IND_WIDTH'(1);
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_press_counter_if.sv
`default_nettype none
// ============================================================================
//  Module   : button_press_counter_if
//  Brief    : Board-side pins of the press counter: controls in, display out
//  Revision : 1.0 - initial release
// ============================================================================
interface button_press_counter_if;
    import button_press_counter_pkg::*;

    logic                     activator;
    logic [NUM_BUTTONS-1:0]   buttons;
    logic [NUM_BUTTONS-1:0]   equalizer;
    logic [7:0]               display;
    logic [c_IND_WIDTH-1:0]   indicator;

    modport master (
        output activator,
        output buttons,
        output equalizer,
        input  display,
        input  indicator
    );

    modport slave (
        input  activator,
        input  buttons,
        input  equalizer,
        output display,
        output indicator
    );
endinterface
`default_nettype wire

// File: rtl/button_press_counter_input_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : input_sync_edge
//  Brief    : Multi-stage synchroniser followed by a rising-edge detector
//  Revision : 1.0 - initial release
// ============================================================================
module input_sync_edge #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_async,
    output logic      [WIDTH-1:0] o_level,
    output logic      [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;

    for (genvar gs = 0; gs < SYNC_STAGES; gs++) begin : g_stage
        if (gs == 0) begin : g_first
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_sync[gs] <= '0;
                else     r_sync[gs] <= i_async;
            end
        end else begin : g_chain
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_sync[gs] <= '0;
                else     r_sync[gs] <= r_sync[gs-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_prev <= '0;
        else     r_prev <= r_sync[SYNC_STAGES-1];
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/button_press_counter.sv
`default_nettype none
// ============================================================================
//  Module   : button_press_counter
//  Brief    : Per-button saturating press counters with equalizer; shows the
//             leading button on a 7-segment digit and the lead count on a bar
//  Revision : 1.0 - initial release
// ============================================================================
module button_press_counter
    import button_press_counter_pkg::*;
#(
    parameter int COUNT_WIDTH = 8,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic               clk,
    input  wire logic               rst,
    button_press_counter_if.slave   bus
);

    logic [NUM_BUTTONS-1:0] w_btn_level;
    logic [NUM_BUTTONS-1:0] w_btn_rise;
    logic [NUM_BUTTONS-1:0] w_eq_level;
    logic [NUM_BUTTONS-1:0] w_eq_rise;
    logic                   w_act;
    logic                   w_unused_act_rise;
    logic                   w_unused_bits;

    input_sync_edge #(.WIDTH(NUM_BUTTONS), .SYNC_STAGES(SYNC_STAGES)) u_sync_btn (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.buttons),
        .o_level (w_btn_level),
        .o_rise  (w_btn_rise)
    );

    input_sync_edge #(.WIDTH(NUM_BUTTONS), .SYNC_STAGES(SYNC_STAGES)) u_sync_eq (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.equalizer),
        .o_level (w_eq_level),
        .o_rise  (w_eq_rise)
    );

    input_sync_edge #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES)) u_sync_act (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.activator),
        .o_level (w_act),
        .o_rise  (w_unused_act_rise)
    );

    assign w_unused_bits = ^{w_btn_level, w_eq_level, w_unused_act_rise};

    logic [COUNT_WIDTH-1:0] r_cnt  [NUM_BUTTONS];
    logic [COUNT_WIDTH-1:0] w_next [NUM_BUTTONS];
    logic [COUNT_WIDTH-1:0] w_max;
    leader_e                w_lead;
    logic [7:0]             r_display;
    logic [c_IND_WIDTH-1:0] r_indicator;

    always_comb begin
        w_max = r_cnt[0];
        for (int i = 1; i < NUM_BUTTONS; i++)
            if (r_cnt[i] > w_max) w_max = r_cnt[i];
    end

    // Equalize first (to the pre-update max), then add the press on top.
    always_comb begin
        logic [COUNT_WIDTH-1:0] v_base;
        v_base = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            v_base = w_eq_rise[i] ? w_max : r_cnt[i];
            if (!w_act)
                w_next[i] = '0;
            else if (w_btn_rise[i])
                w_next[i] = (&v_base) ? v_base : v_base + COUNT_WIDTH'(1);
            else
                w_next[i] = v_base;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_BUTTONS; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_BUTTONS; i++) r_cnt[i] <= w_next[i];
        end
    end

    always_comb begin
        if (r_cnt[0] > r_cnt[1] && r_cnt[0] > r_cnt[2])
            w_lead = LEAD_0;
        else if (r_cnt[1] > r_cnt[0] && r_cnt[1] > r_cnt[2])
            w_lead = LEAD_1;
        else if (r_cnt[2] > r_cnt[0] && r_cnt[2] > r_cnt[1])
            w_lead = LEAD_2;
        else
            w_lead = LEAD_TIE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_display   <= SEG_TIE;
            r_indicator <= '0;
        end else begin
            r_display   <= seg_encode(w_lead);
            r_indicator <= thermometer(32'(w_max));
        end
    end

    assign bus.display   = r_display;
    assign bus.indicator = r_indicator;

endmodule
`default_nettype wire

// File: tb/tb_button_press_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_press_counter
//  Brief    : Directed self-checking bench for button_press_counter
//  Revision : 1.0 - initial release
// ============================================================================
module tb_button_press_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    button_press_counter_if bus();

    button_press_counter #(.COUNT_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int b);
        bus.buttons[b] = 1'b1;
        cyc(1);
        bus.buttons[b] = 1'b0;
        cyc(1);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_game();
        bus.activator = 1'b0;
        bus.equalizer = '0;
        cyc(10);
        bus.activator = 1'b1;
        cyc(5);
    endtask

    initial begin
        bus.activator = 1'b1;
        bus.buttons   = '0;
        bus.equalizer = '0;
        cyc(3);
        rst = 1'b0;
        check("reset_display", 32'(bus.display), 32'h7F);
        check("reset_indicator", 32'(bus.indicator), 32'h000);
        cyc(10);
        check("idle_display", 32'(bus.display), 32'h7F);
        check("idle_indicator", 32'(bus.indicator), 32'h000);

        // Three single-cycle pulses on button 2
        repeat (3) press(2);
        cyc(20);
        check("b2x3_display", 32'(bus.display), 32'hA4);
        check("b2x3_indicator", 32'(bus.indicator), 32'h007);

        // Disable clears, then equalize button 0 to the leader
        bus.activator = 1'b0;
        cyc(10);
        check("disabled_display", 32'(bus.display), 32'h7F);
        check("disabled_indicator", 32'(bus.indicator), 32'h000);
        bus.activator = 1'b1;
        cyc(5);
        repeat (3) press(2);
        bus.equalizer[0] = 1'b1;
        cyc(20);
        check("eq0_tie_display", 32'(bus.display), 32'h7F);
        check("eq0_cnt0", 32'(dut.r_cnt[0]), 32'd3);
        check("eq0_indicator", 32'(bus.indicator), 32'h007);

        // Equalizer still held: a press on button 0 just adds one
        press(0);
        cyc(10);
        check("b0_lead_display", 32'(bus.display), 32'hC0);
        check("b0_lead_indicator", 32'(bus.indicator), 32'h00F);

        // Long hold on button 1 counts once
        clear_game();
        bus.buttons[1] = 1'b1;
        cyc(50);
        check("hold_cnt1", 32'(dut.r_cnt[1]), 32'd1);
        check("hold_display", 32'(bus.display), 32'hF9);
        check("hold_indicator", 32'(bus.indicator), 32'h001);

        // Button still held through disable/re-enable: no spurious count
        bus.activator = 1'b0;
        cyc(10);
        bus.activator = 1'b1;
        cyc(10);
        check("reenable_held_cnt1", 32'(dut.r_cnt[1]), 32'd0);
        check("reenable_held_display", 32'(bus.display), 32'h7F);
        bus.buttons[1] = 1'b0;
        cyc(2);

        // Saturation at 255
        clear_game();
        repeat (260) press(2);
        cyc(10);
        check("sat_cnt2", 32'(dut.r_cnt[2]), 32'd255);
        check("sat_display", 32'(bus.display), 32'hA4);
        check("sat_indicator", 32'(bus.indicator), 32'h3FF);
        bus.equalizer[0] = 1'b1;
        bus.buttons[0]   = 1'b1;
        cyc(1);
        bus.buttons[0]   = 1'b0;
        cyc(10);
        check("sat_eq_press_cnt0", 32'(dut.r_cnt[0]), 32'd255);
        check("sat_tie_display", 32'(bus.display), 32'h7F);

        // Equalize and press in the same cycle with counts 2/0/0
        clear_game();
        repeat (2) press(0);
        cyc(10);
        check("two_b0_display", 32'(bus.display), 32'hC0);
        check("two_b0_indicator", 32'(bus.indicator), 32'h003);
        bus.buttons[1]   = 1'b1;
        bus.equalizer[1] = 1'b1;
        cyc(1);
        bus.buttons[1]   = 1'b0;
        cyc(10);
        check("eq_press_cnt1", 32'(dut.r_cnt[1]), 32'd3);
        check("eq_press_display", 32'(bus.display), 32'hF9);
        check("eq_press_indicator", 32'(bus.indicator), 32'h007);

        // Two equalize edges together, both take the same max (3)
        bus.equalizer[1] = 1'b0;
        cyc(2);
        bus.equalizer[0] = 1'b1;
        bus.equalizer[2] = 1'b1;
        cyc(10);
        check("multi_eq_cnt0", 32'(dut.r_cnt[0]), 32'd3);
        check("multi_eq_cnt2", 32'(dut.r_cnt[2]), 32'd3);
        check("multi_eq_display", 32'(bus.display), 32'h7F);
        press(1);
        cyc(10);
        check("b1_lead_display", 32'(bus.display), 32'hF9);
        check("b1_lead_indicator", 32'(bus.indicator), 32'h00F);

        // Asynchronous reset mid-game, observed before the next edge
        #3 rst = 1'b1;
        #1;
        check("async_rst_display", 32'(bus.display), 32'h7F);
        check("async_rst_indicator", 32'(bus.indicator), 32'h000);
        bus.equalizer = '0;
        cyc(3);
        rst = 1'b0;
        cyc(10);
        check("post_rst_cnt1", 32'(dut.r_cnt[1]), 32'd0);
        check("post_rst_display", 32'(bus.display), 32'h7F);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
